// File: rtl/audio_pwm_dac.sv
// PWM audio DAC: prescaled carrier, period-aligned duty latch, sample tick, 4-register bus slave.
// Optional AUDIO_PWM_DAC_DSM_EN adds CTRL.MODE selecting a first-order delta-sigma output.
module audio_pwm_dac #(
    parameter int         WIDTH        = 12,
    parameter logic [7:0] PRESCALE_RST = 8'd0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    output logic             ready,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] sample,
    output logic             pwm_out,
    output logic             sample_tick
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             en_q, en_d;
    logic             inv_q, inv_d;
    logic [7:0]       prescale_q, prescale_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [7:0]       pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;
`ifdef AUDIO_PWM_DAC_DSM_EN
    logic             mode_q, mode_d;
    logic [WIDTH:0]   acc_q, acc_d;
`endif

    logic        accept, ctrl_wr, ps_wr, step, wrap, start;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign unused_bits = ^{wstrb[3:1], addr[31:4], addr[1:0], wdata[31:8]};

    always_comb begin
        accept  = valid & ~ready_q;
        ctrl_wr = accept & wstrb[0] & (addr[3:2] == 2'd0);
        ps_wr   = accept & wstrb[0] & (addr[3:2] == 2'd1);

        rd_val = '0;
        case (addr[3:2])
`ifdef AUDIO_PWM_DAC_DSM_EN
            2'd0:    rd_val = {29'd0, mode_q, inv_q, en_q};
`else
            2'd0:    rd_val = {30'd0, inv_q, en_q};
`endif
            2'd1:    rd_val = {24'd0, prescale_q};
            2'd2:    rd_val = 32'(duty_q);
            default: rd_val = 32'(cnt_q);
        endcase

        ready_d    = accept;
        rdata_d    = accept ? rd_val : '0;
        en_d       = ctrl_wr ? wdata[0] : en_q;
        inv_d      = ctrl_wr ? wdata[1] : inv_q;
        prescale_d = ps_wr ? wdata[7:0] : prescale_q;

        // A wrap always follows the pre-write EN, so a CTRL write on that edge
        // cannot suppress the duty latch.
        step  = en_q & (pre_q == prescale_q);
        wrap  = step & (cnt_q == CNT_MAX);
        start = ctrl_wr & wdata[0] & ~en_q;

        tick_d = wrap | start;
        duty_d = (wrap | start) ? sample : duty_q;

        if (!en_q) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            pre_d = step ? 8'd0 : pre_q + 8'd1;
            cnt_d = step ? cnt_q + WIDTH'(1) : cnt_q;
        end

        pwm_d = en_q & ((cnt_q < duty_q) ^ inv_q);
`ifdef AUDIO_PWM_DAC_DSM_EN
        mode_d = ctrl_wr ? wdata[2] : mode_q;
        if (!en_q)
            acc_d = '0;
        else if (step)
            acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, duty_q};
        else
            acc_d = acc_q;
        if (mode_q)
            pwm_d = en_q & (acc_q[WIDTH] ^ inv_q);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            prescale_q <= PRESCALE_RST;
            duty_q     <= '0;
            pre_q      <= '0;
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
`ifdef AUDIO_PWM_DAC_DSM_EN
            mode_q     <= 1'b0;
            acc_q      <= '0;
`endif
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            inv_q      <= inv_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
`ifdef AUDIO_PWM_DAC_DSM_EN
            mode_q     <= mode_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign rdata       = rdata_q;
    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: register access, duty/period counting, prescale, reset mid-period.
module tb_audio_pwm_dac;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [11:0] sample;
    logic        pwm_out;
    logic        sample_tick;

    int n_checks = 0;
    int n_errors = 0;

    audio_pwm_dac #(.WIDTH(12), .PRESCALE_RST(8'd0)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata),
        .sample(sample), .pwm_out(pwm_out), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the falling edge just after the accepting clock edge.
    task automatic bus_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rd);
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        wdata = wd;
        wstrb = wr ? 4'h1 : 4'h0;
        @(posedge clk);
        #1;
        check("bus_ready", {31'd0, ready}, 32'd1);
        rd = rdata;
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic wait_tick(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (sample_tick) seen = 1'b1;
        end
        check("tick_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic measure(input int n, input int change_at, input logic [11:0] nxt,
                           output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            ticks += int'(sample_tick);
            if (i == change_at) sample = nxt;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int hi, tk;
        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = '0;
        wdata  = '0;
        sample = 12'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pwm", {31'd0, pwm_out}, 32'd0);
        check("rst_tick", {31'd0, sample_tick}, 32'd0);
        resetn = 1'b1;

        bus_xfer(32'h0, 1'b0, 0, rd); check("rd_ctrl", rd, 32'd0);
        @(posedge clk); #1;
        check("ready_drops", {31'd0, ready}, 32'd0);
        bus_xfer(32'h4, 1'b0, 0, rd); check("rd_prescale", rd, 32'd0);
        bus_xfer(32'h8, 1'b0, 0, rd); check("rd_duty", rd, 32'd0);
        bus_xfer(32'hC, 1'b0, 0, rd); check("rd_cnt", rd, 32'd0);

        // Enable with duty 1024 at PRESCALE=0.
        sample = 12'd1024;
        bus_xfer(32'h0, 1'b1, 32'd1, rd);
        check("start_tick", {31'd0, sample_tick}, 32'd1);
        bus_xfer(32'hC, 1'b0, 0, rd); check("rd_cnt_run", rd, 32'd1);
        bus_xfer(32'h8, 1'b0, 0, rd); check("rd_duty_1024", rd, 32'd1024);
        wait_tick(5000);
        measure(4096, 2048, 12'd0, hi, tk);
        check("p1024_high", hi, 32'd1024);
        check("p1024_ticks", tk, 32'd1);
        measure(4096, 2048, 12'd4095, hi, tk);
        check("p0_high", hi, 32'd0);
        measure(4096, 2048, 12'd0, hi, tk);
        check("p4095_high", hi, 32'd4095);
        check("p4095_ticks", tk, 32'd1);

        // Inverted output with duty 0.
        bus_xfer(32'h0, 1'b1, 32'd3, rd);
        wait_tick(5000);
        measure(4096, 2048, 12'd2048, hi, tk);
        check("inv0_high", hi, 32'd4096);

        // Prescale 3: 16384-cycle period.
        bus_xfer(32'h0, 1'b1, 32'd1, rd);
        bus_xfer(32'h4, 1'b1, 32'd3, rd);
        bus_xfer(32'h4, 1'b0, 0, rd); check("rd_prescale3", rd, 32'd3);
        wait_tick(20000);
        measure(16384, 8192, 12'd100, hi, tk);
        check("ps3_high", hi, 32'd8192);
        check("ps3_ticks", tk, 32'd1);

        // Mid-period sample change is deferred to the next period.
        bus_xfer(32'h4, 1'b1, 32'd0, rd);
        wait_tick(20000);
        measure(4096, 500, 12'd3000, hi, tk);
        check("mid_chg_high", hi, 32'd100);
        measure(2000, 0, 12'd0, hi, tk);
        check("next_high", hi, 32'd2000);
        check("next_ticks", tk, 32'd0);

        // Reset asserted mid-period.
        check("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
        check("midrst_tick", {31'd0, sample_tick}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bus_xfer(32'h0, 1'b0, 0, rd); check("post_rst_ctrl", rd, 32'd0);
        measure(16, 0, 12'd0, hi, tk);
        check("idle_high", hi, 32'd0);
        check("idle_ticks", tk, 32'd0);

        sample = 12'd1024;
        bus_xfer(32'h0, 1'b1, 32'd5, rd);
        bus_xfer(32'h0, 1'b0, 0, rd);
`ifdef AUDIO_PWM_DAC_DSM_EN
        check("ctrl_mode_rb", rd, 32'd5);
        begin
            int last = -1;
            int gap_err = 0;
            hi = 0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (pwm_out) begin
                    hi++;
                    if (last >= 0 && i - last != 4) gap_err++;
                    last = i;
                end
            end
            check("dsm_high", hi, 32'd16);
            check("dsm_gap", gap_err, 32'd0);
        end
`else
        check("ctrl_mode_rb", rd, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_pwm_dac.md
Name: audio_pwm_dac

Overview:
- Downstream stage of the channel mixer. Consumes the mixer's 12-bit mixed sample and drives a single-bit PWM audio pin for an external RC low-pass filter.
- Provides a prescaled PWM carrier, period-aligned sample latching and a one-cycle sample tick.
- Has a small memory-mapped register file on the same valid/ready peripheral bus used by the mixer.

Parameters:
- WIDTH, 12, sample and PWM counter width; period = 2^WIDTH steps.
- PRESCALE_RST, 0, reset value of the PRESCALE register; step length = PRESCALE+1 clk cycles.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous assert, active-low
- valid  in  1  bus request
- ready  out  1  bus acknowledge
- wstrb  in  4  byte write strobes; only wstrb[0] is used
- addr  in  32  byte address; addr[3:2] selects the register
- wdata  in  32  write data
- rdata  out  32  read data
- sample  in  WIDTH  mixed sample from the mixer's out port
- pwm_out  out  1  PWM audio output
- sample_tick  out  1  one-cycle pulse at each period start

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0 (ready, rdata, pwm_out, sample_tick). CTRL=0, PRESCALE=PRESCALE_RST, duty=0, step counter pre=0, period counter cnt=0.
- Register map (addr[3:2]):
  - 0 CTRL: bit0 EN, bit1 INV.
  - 1 PRESCALE[7:0].
  - 2 DUTY, read-only: the latched duty.
  - 3 CNT, read-only: current cnt.
  - Unused bits read 0.
- Bus transfer:
  - Accepted on a clk edge where valid=1 and ready=0. That edge sets ready=1 for exactly one cycle and drives rdata for that cycle.
  - A write occurs on the same edge when wstrb[0]=1, using wdata[7:0]. Writes to read-only registers are ignored.
  - Reads return the pre-write value.
  - With valid held high, a new transfer is accepted every second cycle.
  - ready is 0 while valid=0.
- EN=0:
  - pre and cnt are held at 0, pwm_out=0 (INV is ignored), sample_tick=0.
  - duty keeps its value.
- Writing EN 0->1:
  - On the first enabled cycle, duty<=sample and sample_tick=1 for 1 cycle. Counting starts from pre=0, cnt=0.
- Step:
  - pre counts 0..PRESCALE; on pre==PRESCALE, pre<=0 and the step fires.
  - PRESCALE=0 means a step every cycle.
  - PRESCALE changes take effect at the next pre wrap. If the new value is below the current pre, pre wraps at 255 then continues normally.
- Period:
  - On each step, cnt<=cnt+1 (mod 2^WIDTH).
  - On the step where cnt==2^WIDTH-1, cnt<=0, duty<=sample, and sample_tick=1 on the following cycle only.
- Output:
  - pwm_out is registered: pwm_out <= EN & ((cnt<duty) ^ INV), evaluated with the current register values, so it lags cnt by 1 cycle.
  - duty=0 gives constant low; duty=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH steps.
- sample is sampled only at period start. Changes mid-period do not affect the current period.
- A bus write to CTRL and a period wrap on the same edge: the wrap uses the old EN, and the new EN applies from the next cycle. Writing EN=0 on a wrap edge still latches duty.
- Reset asserted mid-period: all state clears immediately. After release, EN=0 and the block is idle.

Optional Feature:
- Macro: AUDIO_PWM_DAC_DSM_EN.
- Defined:
  - CTRL bit2 MODE is writable and readable.
  - MODE=1 selects first-order delta-sigma. A WIDTH+1-bit accumulator acc is cleared while EN=0.
  - On each step, acc <= {0,acc[WIDTH-1:0]} + duty, and pwm_out <= EN & (acc carry bit ^ INV).
  - The period counter, duty latching and sample_tick timing are unchanged.
  - MODE=0 gives PWM as specified above.
- Not defined: CTRL bit2 reads 0, writes to it are ignored, and no accumulator exists.

Test Plan:
- Reset, then read all 4 addresses -> rdata=0 except PRESCALE=PRESCALE_RST. ready pulses once per read, one cycle after valid.
- WIDTH=12, PRESCALE=0, sample=1024, write CTRL=1 -> sample_tick on the first enabled cycle. Each 4096-cycle period has exactly 1024 cycles of pwm_out=1. DUTY reads 1024.
- sample=0, then 4095, INV=0 -> pwm_out constantly 0. After the next wrap, high 4095 of 4096 cycles. With INV=1 and sample=0 -> constantly 1.
- PRESCALE=3, sample=2048 -> period of 16384 cycles, sample_tick every 16384 cycles, pwm_out high for 8192.
- Change sample from 100 to 3000 at cnt=500 -> current period keeps 100 high steps, next period 3000. Assert resetn low at cnt=2000 -> pwm_out and sample_tick are 0 immediately, and CTRL reads 0 after release.
- With AUDIO_PWM_DAC_DSM_EN, MODE=1, sample=1024, PRESCALE=0 -> pwm_out is high exactly every 4th cycle. Without the macro, writing CTRL=5 reads back 1.
